// File: rtl/mirror_check_seq_if.sv
// ----------------------------------------------------------------------------
// mirror_check_seq_if
// Bundles the input and result handshakes of mirror_check_seq.
//
// Parameter:
//   W          half-width of in_data (number of mirrored bit pairs)
//
// Signals (direction seen from the checker, i.e. the slave modport):
//   in_valid   in   in_data is valid
//   in_ready   out  checker accepts in_data this cycle
//   in_data    in   {b, a}; a = in_data[W-1:0], b = in_data[2W-1:W]
//   out_valid  out  result fields are valid
//   out_ready  in   consumer accepts the result
//   out        out  1 = every checked pair equal
//   mism_cnt   out  number of mismatching pairs among the checked pairs
//   first_idx  out  lowest mismatching pair index, 0 if none
//   busy       out  comparison in progress
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer holds data stable while
// valid is high and not yet taken; ready never depends combinationally on
// valid.
// ----------------------------------------------------------------------------
interface mirror_check_seq_if #(
    parameter int W = 5
);
    localparam int CW = $clog2(W + 1);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    logic            in_valid;
    logic            in_ready;
    logic [2*W-1:0]  in_data;
    logic            out_valid;
    logic            out_ready;
    logic            out;
    logic [CW-1:0]   mism_cnt;
    logic [IW-1:0]   first_idx;
    logic            busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out, mism_cnt, first_idx, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out, mism_cnt, first_idx, busy
    );
endinterface

// File: rtl/mirror_check_seq.sv
// ----------------------------------------------------------------------------
// mirror_check_seq
// Sequential mirror checker: captures a 2W-bit word {b, a} and compares the
// pairs (a[k], b[k]) CHUNK at a time, reporting whether all checked pairs
// match, how many mismatch, and the lowest mismatching index.
//
// Parameters:
//   W           number of mirrored bit pairs (>= 1)
//   CHUNK       pairs compared per cycle (1..W, divides W)
//   EARLY_EXIT  1 = finish after the first chunk that holds a mismatch
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          mirror_check_seq_if.slave (input word, result, busy)
//   dbg_state_o  current FSM state (IDLE=0, CHECK=1, DONE=2)
//
// Handshake rule: see mirror_check_seq_if. in_ready is high only in IDLE
// (and low while rst is high); out_valid is high only in DONE.
// ----------------------------------------------------------------------------
module mirror_check_seq #(
    parameter int W          = 5,
    parameter int CHUNK      = 1,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    mirror_check_seq_if.slave   bus,
    output logic [1:0]          dbg_state_o
);

    localparam int NCH = W / CHUNK;
    localparam int CW  = $clog2(W + 1);
    localparam int IW  = (W > 1) ? $clog2(W) : 1;
    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (W < 1 || CHUNK < 1 || CHUNK > W || (W % CHUNK) != 0) begin : g_bad_params
            $error("mirror_check_seq: illegal W/CHUNK combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  data_q, data_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   acc_q, acc_d;        // running mismatch count
    logic [IW-1:0]   idx_q, idx_d;        // running first mismatch index
    logic            found_q, found_d;    // idx_q holds a real mismatch
    logic            res_out_q, res_out_d;
    logic [CW-1:0]   res_cnt_q, res_cnt_d;
    logic [IW-1:0]   res_idx_q, res_idx_d;

    logic [W-1:0]    diff;
    logic [CW-1:0]   pop;
    logic            hit;
    logic [IW-1:0]   hit_idx;
    logic [CW-1:0]   acc_sum;
    logic            accept;
    logic            last_chunk;

    // Mismatches inside the chunk selected by ptr_q. Scanning k upward means
    // the first hit is the lowest index in the chunk; because chunks are
    // visited in ascending order it is also the lowest index overall.
    always_comb begin
        diff    = data_q[W-1:0] ^ data_q[2*W-1:W];
        pop     = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < W; k++) begin
            if ((k / CHUNK) == int'(ptr_q) && diff[k]) begin
                pop = pop + CW'(1);
                if (!hit) begin
                    hit     = 1'b1;
                    hit_idx = IW'(k);
                end
            end
        end
    end

    assign acc_sum    = acc_q + pop;
    assign last_chunk = (ptr_q == PW'(NCH - 1));
    assign accept     = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        ptr_d     = ptr_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        found_d   = found_q;
        res_out_d = res_out_q;
        res_cnt_d = res_cnt_q;
        res_idx_d = res_idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = bus.in_data;
                    ptr_d   = '0;
                    acc_d   = '0;
                    idx_d   = '0;
                    found_d = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                acc_d = acc_sum;
                ptr_d = ptr_q + PW'(1);
                if (!found_q && hit) begin
                    found_d = 1'b1;
                    idx_d   = hit_idx;
                end
                if (last_chunk || (EARLY_EXIT && hit)) begin
                    // Result registers are separate from the accumulators
                    // so the previous result stays visible during CHECK.
                    state_d   = DONE;
                    res_cnt_d = acc_sum;
                    res_out_d = (acc_sum == '0);
                    res_idx_d = found_q ? idx_q : hit_idx;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            ptr_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            found_q   <= 1'b0;
            res_out_q <= 1'b0;
            res_cnt_q <= '0;
            res_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            found_q   <= found_d;
            res_out_q <= res_out_d;
            res_cnt_q <= res_cnt_d;
            res_idx_q <= res_idx_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == CHECK);
    assign bus.out       = res_out_q;
    assign bus.mism_cnt  = res_cnt_q;
    assign bus.first_idx = res_idx_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mirror_check_seq.sv
// ----------------------------------------------------------------------------
// tb_mirror_check_seq
// Bench for mirror_check_seq. Two groups of instances share stimulus:
//   W=5 group: [0] CHUNK=1, [1] CHUNK=1 EARLY_EXIT=1, [2] CHUNK=5
//   W=8 group: [0..3] CHUNK=1,2,4,8, [4] CHUNK=2 EARLY_EXIT=1
// ----------------------------------------------------------------------------
module tb_mirror_check_seq;

  logic clk;
  logic rst;

  int checks;
  int errors;

  // W=5 group
  logic            in5_valid;
  logic            out5_ready;
  logic [9:0]      in5_data;
  logic [2:0]      r5_in_ready, r5_out_valid, r5_out, r5_busy;
  logic [2:0][2:0] r5_cnt;
  logic [2:0][2:0] r5_idx;
  logic [2:0][1:0] r5_dbg;

  // W=8 group
  logic            in8_valid;
  logic            out8_ready;
  logic [15:0]     in8_data;
  logic [4:0]      r8_in_ready, r8_out_valid, r8_out, r8_busy;
  logic [4:0][3:0] r8_cnt;
  logic [4:0][2:0] r8_idx;
  logic [4:0][1:0] r8_dbg;

  // Observations captured by the driver tasks
  int         lat5[3];
  logic       got5_out[3];
  logic [2:0] got5_cnt[3];
  logic [2:0] got5_idx[3];
  int         lat8[5];
  logic       got8_out[5];
  logic [3:0] got8_cnt[5];
  logic [2:0] got8_idx[5];

  generate
    for (genvar g = 0; g < 3; g++) begin : g5
      localparam int CH = (g == 2) ? 5 : 1;
      localparam bit EE = (g == 1);
      mirror_check_seq_if #(.W(5)) bus ();
      assign bus.in_valid     = in5_valid;
      assign bus.in_data      = in5_data;
      assign bus.out_ready    = out5_ready;
      assign r5_in_ready[g]   = bus.in_ready;
      assign r5_out_valid[g]  = bus.out_valid;
      assign r5_out[g]        = bus.out;
      assign r5_busy[g]       = bus.busy;
      assign r5_cnt[g]        = bus.mism_cnt;
      assign r5_idx[g]        = bus.first_idx;
      mirror_check_seq #(.W(5), .CHUNK(CH), .EARLY_EXIT(EE)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(r5_dbg[g])
      );
    end
    for (genvar g = 0; g < 5; g++) begin : g8
      localparam int CH = (g == 4) ? 2 : (1 << g);
      localparam bit EE = (g == 4);
      mirror_check_seq_if #(.W(8)) bus ();
      assign bus.in_valid     = in8_valid;
      assign bus.in_data      = in8_data;
      assign bus.out_ready    = out8_ready;
      assign r8_in_ready[g]   = bus.in_ready;
      assign r8_out_valid[g]  = bus.out_valid;
      assign r8_out[g]        = bus.out;
      assign r8_busy[g]       = bus.busy;
      assign r8_cnt[g]        = bus.mism_cnt;
      assign r8_idx[g]        = bus.first_idx;
      mirror_check_seq #(.W(8), .CHUNK(CH), .EARLY_EXIT(EE)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(r8_dbg[g])
      );
    end
  endgenerate

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Walks the pairs directly: lowest mismatch, the chunk it falls in, and
  // how many pairs the checker looks at before it stops.
  function automatic void model(input int w, input int ch, input bit ee,
                                input logic [15:0] d, output int cnt,
                                output int idx, output int lat);
    int first;
    int lim;
    first = -1;
    for (int k = w - 1; k >= 0; k--)
      if (d[k] !== d[w + k]) first = k;
    lim = w;
    lat = w / ch;
    if (ee && first >= 0) begin
      lim = (first / ch + 1) * ch;
      lat = first / ch + 1;
    end
    cnt = 0;
    for (int k = 0; k < lim; k++)
      if (d[k] !== d[w + k]) cnt++;
    idx = (first < 0) ? 0 : first;
  endfunction

  function automatic int ch8(input int i);
    return (i == 4) ? 2 : (1 << i);
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge with all instances idle. Offers one word,
  // then records latency (cycles after the accept edge) and the result of
  // each instance. lat = -1 means no result appeared within the budget.
  task automatic run5(input logic [9:0] d);
    bit [2:0] seen;
    seen = '0;
    for (int i = 0; i < 3; i++) lat5[i] = -1;
    out5_ready = 1'b1;
    in5_valid  = 1'b1;
    in5_data   = d;
    @(posedge clk); #1;
    in5_valid = 1'b0;
    for (int n = 1; n <= 20 && seen != 3'b111; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && r5_out_valid[i]) begin
          seen[i]     = 1'b1;
          lat5[i]     = n;
          got5_out[i] = r5_out[i];
          got5_cnt[i] = r5_cnt[i];
          got5_idx[i] = r5_idx[i];
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [15:0] d);
    bit [4:0] seen;
    seen = '0;
    for (int i = 0; i < 5; i++) lat8[i] = -1;
    out8_ready = 1'b1;
    in8_valid  = 1'b1;
    in8_data   = d;
    @(posedge clk); #1;
    in8_valid = 1'b0;
    for (int n = 1; n <= 20 && seen != 5'b11111; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        if (!seen[i] && r8_out_valid[i]) begin
          seen[i]     = 1'b1;
          lat8[i]     = n;
          got8_out[i] = r8_out[i];
          got8_cnt[i] = r8_cnt[i];
          got8_idx[i] = r8_idx[i];
        end
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in5_valid = 1'b0; in5_data = '0; out5_ready = 1'b1;
    in8_valid = 1'b0; in8_data = '0; out8_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (r5_in_ready !== 3'b000 || r8_in_ready !== 5'b00000) begin
      errors++;
      $display("FAIL reset_in_ready_low: got %b/%b want 000/00000", r5_in_ready, r8_in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (r5_in_ready !== 3'b111 || r8_in_ready !== 5'b11111) begin
      errors++;
      $display("FAIL reset_in_ready_high: got %b/%b want 111/11111", r5_in_ready, r8_in_ready);
    end
    checks++;
    if (r5_out_valid !== 3'b000 || r8_out_valid !== 5'b00000) begin
      errors++;
      $display("FAIL reset_out_valid: got %b/%b want 0", r5_out_valid, r8_out_valid);
    end
    checks++;
    if (r5_busy !== 3'b000 || r8_busy !== 5'b00000) begin
      errors++;
      $display("FAIL reset_busy: got %b/%b want 0", r5_busy, r8_busy);
    end
    checks++;
    if (r5_out !== 3'b000 || r8_out !== 5'b00000) begin
      errors++;
      $display("FAIL reset_out: got %b/%b want 0", r5_out, r8_out);
    end
    checks++;
    if (r5_cnt !== '0 || r8_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mism_cnt: got %h/%h want 0", r5_cnt, r8_cnt);
    end
    checks++;
    if (r5_idx !== '0 || r8_idx !== '0) begin
      errors++;
      $display("FAIL reset_first_idx: got %h/%h want 0", r5_idx, r8_idx);
    end
  endtask

  // Known-answer vectors on the W=5 group; columns are instances 0,1,2.
  task automatic test_directed();
    logic [9:0] vec[3];
    int e_lat[3][3];
    int e_cnt[3][3];
    int e_idx[3][3];
    vec   = '{10'h021, 10'h140, 10'h3E0};
    e_lat = '{'{5, 5, 1}, '{5, 2, 1}, '{5, 1, 1}};
    e_cnt = '{'{0, 0, 0}, '{2, 1, 2}, '{5, 1, 5}};
    e_idx = '{'{0, 0, 0}, '{1, 1, 1}, '{0, 0, 0}};
    for (int v = 0; v < 3; v++) begin
      run5(vec[v]);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (lat5[i] != e_lat[v][i]) begin
          errors++;
          $display("FAIL directed_latency v=%h inst=%0d: got %0d want %0d", vec[v], i, lat5[i], e_lat[v][i]);
        end
        checks++;
        if (int'(got5_cnt[i]) != e_cnt[v][i]) begin
          errors++;
          $display("FAIL directed_mism_cnt v=%h inst=%0d: got %0d want %0d", vec[v], i, got5_cnt[i], e_cnt[v][i]);
        end
        checks++;
        if (int'(got5_idx[i]) != e_idx[v][i]) begin
          errors++;
          $display("FAIL directed_first_idx v=%h inst=%0d: got %0d want %0d", vec[v], i, got5_idx[i], e_idx[v][i]);
        end
        checks++;
        if (got5_out[i] !== (e_cnt[v][i] == 0)) begin
          errors++;
          $display("FAIL directed_out v=%h inst=%0d: got %b want %b", vec[v], i, got5_out[i], e_cnt[v][i] == 0);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    out5_ready = 1'b0;
    in5_valid  = 1'b1;
    in5_data   = 10'h140;
    @(posedge clk); #1;
    // keep offering a different word while busy; it must not be taken
    in5_data = 10'h021;
    n = 0;
    while (r5_out_valid != 3'b111 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (r5_out_valid !== 3'b111) begin
      errors++;
      $display("FAIL bp_reach_done: got out_valid=%b want 111", r5_out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (r5_out_valid !== 3'b111 || r5_in_ready !== 3'b000) begin
        errors++;
        $display("FAIL bp_hold_handshake c=%0d: got valid=%b ready=%b want 111/000", c, r5_out_valid, r5_in_ready);
      end
      checks++;
      if (r5_cnt !== {3'd2, 3'd1, 3'd2} || r5_idx !== {3'd1, 3'd1, 3'd1} || r5_out !== 3'b000) begin
        errors++;
        $display("FAIL bp_hold_result c=%0d: got cnt=%h idx=%h out=%b want cnt=%h idx=%h out=000",
                 c, r5_cnt, r5_idx, r5_out, {3'd2, 3'd1, 3'd2}, {3'd1, 3'd1, 3'd1});
      end
      @(posedge clk); #1;
    end
    out5_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (r5_out_valid !== 3'b000 || r5_in_ready !== 3'b111 || r5_busy !== 3'b000) begin
      errors++;
      $display("FAIL bp_release_idle: got valid=%b ready=%b busy=%b want 000/111/000", r5_out_valid, r5_in_ready, r5_busy);
    end
    checks++;
    if (r5_cnt !== {3'd2, 3'd1, 3'd2}) begin
      errors++;
      $display("FAIL bp_idle_holds_result: got cnt=%h want %h", r5_cnt, {3'd2, 3'd1, 3'd2});
    end
    @(posedge clk); #1;
    checks++;
    if (r5_busy !== 3'b111 || r5_in_ready !== 3'b000) begin
      errors++;
      $display("FAIL bp_next_accept: got busy=%b ready=%b want 111/000", r5_busy, r5_in_ready);
    end
    in5_valid = 1'b0;
    n = 0;
    while (r5_in_ready != 3'b111 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (r5_in_ready !== 3'b111 || r5_out !== 3'b111 || r5_cnt !== '0) begin
      errors++;
      $display("FAIL bp_second_result: got ready=%b out=%b cnt=%h want 111/111/0", r5_in_ready, r5_out, r5_cnt);
    end
  endtask

  task automatic test_reset_mid_op();
    int n;
    run5(10'h3E0);
    // reset during the third CHECK cycle of the CHUNK=1 instance
    out5_ready = 1'b1;
    in5_valid  = 1'b1;
    in5_data   = 10'h140;
    @(posedge clk); #1;
    in5_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (r5_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_precond_busy: got %b want 1", r5_busy[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (r5_out_valid !== 3'b000 || r5_busy !== 3'b000 || r5_in_ready !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_state: got valid=%b busy=%b ready=%b want 000/000/000", r5_out_valid, r5_busy, r5_in_ready);
    end
    checks++;
    if (r5_cnt !== '0 || r5_idx !== '0 || r5_out !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_result_cleared: got cnt=%h idx=%h out=%b want 0", r5_cnt, r5_idx, r5_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run5(10'h021);
    checks++;
    if (lat5[0] != 5 || got5_out[0] !== 1'b1 || got5_cnt[0] !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_recheck: got lat=%0d out=%b cnt=%0d want 5/1/0", lat5[0], got5_out[0], got5_cnt[0]);
    end
    // reset while a result is waiting in DONE
    out5_ready = 1'b0;
    in5_valid  = 1'b1;
    in5_data   = 10'h3E0;
    @(posedge clk); #1;
    in5_valid = 1'b0;
    n = 0;
    while (r5_out_valid != 3'b111 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (r5_out_valid !== 3'b000 || r5_cnt !== '0) begin
      errors++;
      $display("FAIL rst_in_done: got valid=%b cnt=%h want 000/0", r5_out_valid, r5_cnt);
    end
    rst = 1'b0;
    out5_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] d;
    int ecnt, eidx, elat;
    bit eout;
    for (int t = 0; t < 1000; t++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (8'd1 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      d = {b, a};
      run8(d);
      for (int i = 0; i < 5; i++) begin
        model(8, ch8(i), (i == 4), d, ecnt, eidx, elat);
        eout = (i == 4) ? (ecnt == 0) : (a == b);
        checks++;
        if (lat8[i] != elat) begin
          errors++;
          $display("FAIL rand_latency d=%h inst=%0d: got %0d want %0d", d, i, lat8[i], elat);
        end
        checks++;
        if (got8_out[i] !== eout) begin
          errors++;
          $display("FAIL rand_out d=%h inst=%0d: got %b want %b", d, i, got8_out[i], eout);
        end
        checks++;
        if (int'(got8_cnt[i]) != ecnt) begin
          errors++;
          $display("FAIL rand_mism_cnt d=%h inst=%0d: got %0d want %0d", d, i, got8_cnt[i], ecnt);
        end
        checks++;
        if (int'(got8_idx[i]) != eidx) begin
          errors++;
          $display("FAIL rand_first_idx d=%h inst=%0d: got %0d want %0d", d, i, got8_idx[i], eidx);
        end
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
